// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables, bubble/flush control, trap sequencing
// around memory stalls, a saturating stall counter and a sticky bus-wait watchdog.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        IM_stall,
  input  logic        DM_stall,
  input  logic        ID_EX_mem_read,
  input  logic [4:0]  ID_EX_rd_addr,
  input  logic [4:0]  IF_ID_rs1_addr,
  input  logic [4:0]  IF_ID_rs2_addr,
  input  logic        EX_branch_taken,
  input  logic        CSR_trap,
  output logic        PC_Write,
  output logic        IF_ID_Reg_Write,
  output logic        ID_EX_Reg_Write,
  output logic        EX_MEM_Reg_Write,
  output logic        MEM_WB_Reg_Write,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        CSR_rst,
  output logic [1:0]  state,
  output logic [31:0] stall_cnt,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STALL     = 2'd1,
    TRAP_PEND = 2'd2,
    RSVD      = 2'd3
  } state_t;

  localparam logic [9:0]  WAIT_MAX = 10'd1023;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  state_t      state_r;
  state_t      cur_state_s;
  state_t      state_next_s;
  logic        busy_s;
  logic        trap_now_s;
  logic        load_use_s;
  logic        bubble_s;
  logic [31:0] stall_cnt_r;
  logic [9:0]  wait_cnt_r;
  logic        bus_timeout_r;

  // Hazard detection; while reset is held the controller decodes as if in RUN
  always_comb begin
    busy_s     = IM_stall | DM_stall;
    load_use_s = ID_EX_mem_read & (ID_EX_rd_addr != 5'd0) &
                 ((ID_EX_rd_addr == IF_ID_rs1_addr) | (ID_EX_rd_addr == IF_ID_rs2_addr));
    if (!rst) begin
      cur_state_s = RUN;
    end else begin
      cur_state_s = state_r;
    end
    trap_now_s = ~busy_s & (CSR_trap | (cur_state_s == TRAP_PEND));
    bubble_s   = ~busy_s & ~trap_now_s & ~EX_branch_taken & load_use_s;
  end

  // Next-state logic: a trap requested during a stall is parked in TRAP_PEND
  always_comb begin
    state_next_s = RUN;
    case (cur_state_s)
      RUN, STALL, RSVD: begin
        if (busy_s) begin
          if (CSR_trap) begin
            state_next_s = TRAP_PEND;
          end else begin
            state_next_s = STALL;
          end
        end else begin
          state_next_s = RUN;
        end
      end
      TRAP_PEND: begin
        if (busy_s) begin
          state_next_s = TRAP_PEND;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = RUN;
    endcase
  end

  // Enable/flush outputs, priority busy > trap > branch > load-use > normal
  always_comb begin
    PC_Write         = 1'b1;
    IF_ID_Reg_Write  = 1'b1;
    ID_EX_Reg_Write  = 1'b1;
    EX_MEM_Reg_Write = 1'b1;
    MEM_WB_Reg_Write = 1'b1;
    IF_ID_flush      = 1'b0;
    ID_EX_flush      = 1'b0;
    CSR_rst          = 1'b0;
    if (busy_s) begin
      PC_Write         = 1'b0;
      IF_ID_Reg_Write  = 1'b0;
      ID_EX_Reg_Write  = 1'b0;
      EX_MEM_Reg_Write = 1'b0;
      MEM_WB_Reg_Write = 1'b0;
    end else if (trap_now_s) begin
      CSR_rst = 1'b1;
    end else if (EX_branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use_s) begin
      PC_Write        = 1'b0;
      IF_ID_Reg_Write = 1'b0;
      ID_EX_flush     = 1'b1;
    end else begin
      CSR_rst = 1'b0;
    end
  end

  // State, saturating stall counter and sticky bus-wait watchdog
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= RUN;
      stall_cnt_r   <= 32'd0;
      wait_cnt_r    <= 10'd0;
      bus_timeout_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if ((busy_s | bubble_s) && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (!busy_s) begin
        wait_cnt_r <= 10'd0;
      end else if (wait_cnt_r != WAIT_MAX) begin
        wait_cnt_r <= wait_cnt_r + 10'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (busy_s && (wait_cnt_r == WAIT_MAX)) begin
        bus_timeout_r <= 1'b1;
      end else begin
        bus_timeout_r <= bus_timeout_r;
      end
    end
  end

  assign state       = state_r;
  assign stall_cnt   = stall_cnt_r;
  assign bus_timeout = bus_timeout_r;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-low reset (rst=0 resets).
REQ-003 SHALL have ports: IM_stall  in  1  fetch memory not ready; DM_stall  in  1  data memory not ready.
REQ-004 SHALL have ports: ID_EX_mem_read  in  1  EX-stage instruction is a load; ID_EX_rd_addr  in  5  its destination; IF_ID_rs1_addr, IF_ID_rs2_addr  in  5 each  ID-stage sources.
REQ-005 SHALL have ports: EX_branch_taken  in  1  EX-stage redirect (branch/jump); CSR_trap  in  1  one-cycle interrupt/exception request pulse.
REQ-006 SHALL have ports: PC_Write, IF_ID_Reg_Write, ID_EX_Reg_Write, EX_MEM_Reg_Write, MEM_WB_Reg_Write  out  1 each  stage load enables.
REQ-007 SHALL have ports: IF_ID_flush, ID_EX_flush  out  1 each  insert bubble; CSR_rst  out  1  flush all pipeline registers.
REQ-008 SHALL have ports: state  out  2  FSM state; stall_cnt  out  32  stall-cycle counter; bus_timeout  out  1  sticky memory-wait watchdog flag.

Function
REQ-009 SHALL define busy = IM_stall | DM_stall.
REQ-010 SHALL implement registered FSM states RUN=2'd0, STALL=2'd1, TRAP_PEND=2'd2; 2'd3 SHALL behave as RUN and go to RUN next cycle.
REQ-011 SHALL drive all enable/flush outputs combinationally from the current state and current inputs (zero latency).
REQ-012 Busy cycle (any state): all five enables=0, IF_ID_flush=ID_EX_flush=CSR_rst=0.
REQ-013 Transitions: RUN/STALL + busy + (CSR_trap=0) -> STALL; RUN/STALL + busy + CSR_trap=1 -> TRAP_PEND; TRAP_PEND + busy -> TRAP_PEND; any state + !busy -> RUN.
REQ-014 A trap taken is trap_now = !busy & (CSR_trap | state==TRAP_PEND); CSR_trap pulses arriving during busy SHALL NOT be lost.
REQ-015 trap_now: CSR_rst=1, PC_Write=1, other enables=1, flushes=0; highest priority.
REQ-016 Branch (!busy, !trap_now, EX_branch_taken=1): all enables=1, IF_ID_flush=1, ID_EX_flush=1.
REQ-017 Load-use = ID_EX_mem_read & ID_EX_rd_addr!=0 & (ID_EX_rd_addr==IF_ID_rs1_addr | ID_EX_rd_addr==IF_ID_rs2_addr).
REQ-018 Load-use (!busy, no trap, no branch): PC_Write=0, IF_ID_Reg_Write=0, ID_EX_flush=1, ID_EX/EX_MEM/MEM_WB enables=1, IF_ID_flush=0.
REQ-019 Otherwise (!busy, no event): all enables=1, all flushes and CSR_rst=0.
REQ-020 Priority SHALL be busy > trap > branch > load-use > normal.
REQ-021 stall_cnt SHALL increment by 1 each busy cycle and each load-use bubble cycle, saturating at 32'hFFFF_FFFF.
REQ-022 A 10-bit wait counter SHALL increment each consecutive busy cycle and clear on any !busy cycle; on reaching 10'd1023 (1024th consecutive busy cycle) bus_timeout SHALL be set next edge and stay 1 until reset; the wait counter SHALL hold at 1023.
REQ-023 bus_timeout SHALL NOT alter stall behaviour.

Reset
REQ-024 On rst=0 at a clock edge: state=RUN, stall_cnt=0, wait counter=0, bus_timeout=0; a pending trap SHALL be discarded.
REQ-025 During reset cycles outputs SHALL follow REQ-012..019 from state RUN and current inputs; reset mid-STALL/TRAP_PEND SHALL return to RUN.
REQ-026 No output or state SHALL be X after the first reset edge.

Verification
REQ-027 Reset, idle inputs -> state=0, all enables=1, flushes=0, CSR_rst=0, stall_cnt=0.
REQ-028 DM_stall=1 for 3 cycles with CSR_trap pulsed in cycle 2 -> enables=0 for 3 cycles, state 1 then 2; first !busy cycle CSR_rst=1, PC_Write=1; next cycle state=0, stall_cnt=3.
REQ-029 ID_EX_mem_read=1, rd=5, rs2=5 -> PC_Write=0, IF_ID_Reg_Write=0, ID_EX_flush=1; same with rd=0 -> no bubble; with EX_branch_taken=1 -> both flushes=1, PC_Write=1.
REQ-030 IM_stall held 1024 cycles -> bus_timeout=1 at edge after 1024th cycle, stays 1 after IM_stall drops; rst=0 clears it.
REQ-031 Preload stall_cnt near saturation (run to 32'hFFFF_FFFE via forced/long stall) -> two more busy cycles give 32'hFFFF_FFFF, holds.
REQ-032 rst=0 while state=TRAP_PEND -> next state=RUN, no CSR_rst pulse after release.
